// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK SPI reader: FSM state encoding,
// joystick constants and default bus timing.
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } jstk_state_e;

    localparam logic [9:0] JSTK_CENTER  = 10'd512;
    localparam logic [7:0] JSTK_LED_CMD = 8'h80;

    // Default timing, in clk cycles at 100 MHz
    localparam int unsigned CLK_DIV     = 64;
    localparam int unsigned SS_SETUP    = 1600;
    localparam int unsigned BYTE_GAP    = 1200;
    localparam int unsigned POLL_CYCLES = 1000000;

    localparam int unsigned NUM_BYTES   = 5;

    // Command byte that asks the joystick to drive its LEDs from led bits
    function automatic logic [7:0] jstk_led_cmd(input logic [1:0] leds);
        return JSTK_LED_CMD | {6'b0, leds};
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Single 8-bit SPI mode-0 exchange, MSB first. Each bit is a low half then a
// high half of CLK_DIV clk cycles each; mosi changes at the start of the low
// half and miso is sampled on the edge that raises sclk. The exchange starts
// on the edge where start is high and done is high during the last cycle of
// the 8th high half, when rx_byte already holds the complete byte.
module spi_byte_shifter #(
    parameter int unsigned CLK_DIV = jstk_pkg::CLK_DIV
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       sclk,
    output logic       mosi
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active;
    logic          high_half;
    logic [2:0]    bit_cnt;
    logic [DW-1:0] div_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;

    // Half-period divider, bit sequencing and both shift registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            active    <= 1'b0;
            high_half <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
        end else if (start) begin
            active    <= 1'b1;
            high_half <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            tx_sr     <= tx_byte;
            sclk      <= 1'b0;
            mosi      <= tx_byte[7];
        end else if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (!high_half) begin
                    high_half <= 1'b1;
                    sclk      <= 1'b1;
                    rx_sr     <= {rx_sr[6:0], miso};
                end else begin
                    high_half <= 1'b0;
                    sclk      <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                        mosi   <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                        mosi    <= tx_sr[6];
                    end
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Completion flag for the final cycle of the last high half
    always_comb begin
        done = active && high_half && (div_cnt == DIV_LAST) && (bit_cnt == 3'd7);
    end

    assign rx_byte = rx_sr;

endmodule

// File: rtl/jstk_spi_reader.sv
// PmodJSTK poller: every POLL_CYCLES idle cycles runs a 5-byte SPI exchange
// and publishes X/Y/buttons atomically with a one-cycle sample_valid pulse.
// Build option: define JSTK_LED_EN to send the LED command byte built from
// leds; otherwise the command byte is 0x00 and leds is ignored.
module jstk_spi_reader #(
    parameter int unsigned CLK_DIV     = jstk_pkg::CLK_DIV,
    parameter int unsigned SS_SETUP    = jstk_pkg::SS_SETUP,
    parameter int unsigned BYTE_GAP    = jstk_pkg::BYTE_GAP,
    parameter int unsigned POLL_CYCLES = jstk_pkg::POLL_CYCLES
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       miso,
    input  logic [1:0] leds,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] btn,
    output logic       sample_valid,
    output logic       busy
);

    import jstk_pkg::*;

    localparam int unsigned T_MAX =
        (POLL_CYCLES > SS_SETUP)
            ? ((POLL_CYCLES > BYTE_GAP) ? POLL_CYCLES : BYTE_GAP)
            : ((SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP);
    localparam int unsigned TW = $clog2(T_MAX + 1);

    jstk_state_e state, next_state;

    logic [TW-1:0] timer;
    logic          tmr_clr;
    logic          start;
    logic          next_active;
    logic [2:0]    byte_idx;
    logic [7:0]    cmd_now;
    logic [7:0]    cmd_byte;
    logic [7:0]    tx_byte;
    logic [7:0]    rx_byte;
    logic          shift_done;

    logic [7:0]    x_lo;
    logic [1:0]    x_hi;
    logic [7:0]    y_lo;
    logic [1:0]    y_hi;
    logic [2:0]    btn_rx;

`ifdef JSTK_LED_EN
    assign cmd_now = jstk_led_cmd(leds);
`else
    logic unused_leds;
    assign unused_leds = ^leds;
    assign cmd_now     = 8'h00;
`endif

    assign tx_byte = (byte_idx == 3'd0) ? cmd_byte : 8'h00;

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic, phase timer control and byte-start strobe
    always_comb begin
        next_state = state;
        tmr_clr    = 1'b0;
        start      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (timer == TW'(POLL_CYCLES - 1)) begin
                    next_state = ST_SETUP;
                    tmr_clr    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (timer == TW'(SS_SETUP - 1)) begin
                    next_state = ST_SHIFT;
                    tmr_clr    = 1'b1;
                    start      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    tmr_clr    = 1'b1;
                    next_state = (byte_idx == 3'(NUM_BYTES - 1)) ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer == TW'(BYTE_GAP - 1)) begin
                    next_state = ST_SHIFT;
                    tmr_clr    = 1'b1;
                    start      = 1'b1;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
                tmr_clr    = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
                tmr_clr    = 1'b1;
            end
        endcase
        next_active = (next_state == ST_SETUP) || (next_state == ST_SHIFT) ||
                      (next_state == ST_GAP);
    end

    // Shared phase timer for IDLE, SETUP and GAP; parked at zero while shifting
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                                                   timer <= '0;
        else if (tmr_clr || state == ST_SHIFT || state == ST_DONE) timer <= '0;
        else                                                       timer <= timer + TW'(1);
    end

    // Command latch on SETUP entry, byte index and received-field capture
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cmd_byte <= '0;
            byte_idx <= '0;
            x_lo     <= '0;
            x_hi     <= '0;
            y_lo     <= '0;
            y_hi     <= '0;
            btn_rx   <= '0;
        end else begin
            if (state == ST_IDLE && next_state == ST_SETUP) begin
                cmd_byte <= cmd_now;
                byte_idx <= '0;
            end else if (shift_done) begin
                byte_idx <= byte_idx + 3'd1;
                case (byte_idx)
                    3'd0:    x_lo   <= rx_byte;
                    3'd1:    x_hi   <= rx_byte[1:0];
                    3'd2:    y_lo   <= rx_byte;
                    3'd3:    y_hi   <= rx_byte[1:0];
                    default: btn_rx <= rx_byte[2:0];
                endcase
            end
        end
    end

    // Registered slave select, busy flag and atomic output update on DONE
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ss           <= 1'b1;
            busy         <= 1'b0;
            joy_x        <= JSTK_CENTER;
            joy_y        <= JSTK_CENTER;
            btn          <= '0;
            sample_valid <= 1'b0;
        end else begin
            ss           <= ~next_active;
            busy         <= next_active;
            sample_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                joy_x <= {x_hi, x_lo};
                joy_y <= {y_hi, y_lo};
                btn   <= btn_rx;
            end
        end
    end

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .tx_byte (tx_byte),
        .miso    (miso),
        .rx_byte (rx_byte),
        .done    (shift_done),
        .sclk    (sclk),
        .mosi    (mosi)
    );

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Directed bench for jstk_spi_reader with a behavioural PmodJSTK model that
// shifts a 40-bit response out on falling sclk and records mosi on rising sclk.
module tb_jstk_spi_reader;

    logic       clk = 1'b0;
    logic       clr;
    logic       miso;
    logic [1:0] leds;
    logic       ss, sclk, mosi;
    logic [9:0] joy_x, joy_y;
    logic [2:0] btn;
    logic       sample_valid, busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned pulses = 0;

    logic [39:0] resp     = '0;
    logic [39:0] mosi_cap = '0;
    int unsigned n_fall    = 0;
    int unsigned fall_base = 0;

`ifdef JSTK_LED_EN
    localparam logic [7:0] EXP_CMD = 8'h82;
`else
    localparam logic [7:0] EXP_CMD = 8'h00;
`endif

    jstk_spi_reader #(
        .CLK_DIV     (2),
        .SS_SETUP    (4),
        .BYTE_GAP    (3),
        .POLL_CYCLES (10)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .miso         (miso),
        .leds         (leds),
        .ss           (ss),
        .sclk         (sclk),
        .mosi         (mosi),
        .joy_x        (joy_x),
        .joy_y        (joy_y),
        .btn          (btn),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Joystick model
    always @(negedge sclk) n_fall++;
    always @(negedge ss)   fall_base = n_fall;
    always @(posedge sclk) mosi_cap = {mosi_cap[38:0], mosi};
    assign miso = (ss === 1'b0 && (n_fall - fall_base) < 40) ?
                  resp[39 - (n_fall - fall_base)] : 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Outputs may only move on a sample_valid cycle, except under clr
    logic [9:0] px = 10'd512, py = 10'd512;
    logic [2:0] pb = 3'd0;
    always @(negedge clk) begin
        if (sample_valid) pulses++;
        if ((joy_x !== px || joy_y !== py || btn !== pb) && !sample_valid && clr !== 1'b1)
            check("out_hold", {joy_x, joy_y, btn}, {px, py, pb});
        px = joy_x;
        py = joy_y;
        pb = btn;
    end

    task automatic wait_ss_fall(input int unsigned limit, output int unsigned at);
        int unsigned n = 0;
        while (ss !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (ss !== 1'b0) check("ss_fall_timeout", ss, 0);
        at = cyc;
    endtask

    task automatic wait_pulse(input int unsigned limit, output int unsigned at);
        int unsigned n = 0;
        while (sample_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sample_valid !== 1'b1) check("pulse_timeout", sample_valid, 1);
        at = cyc;
    endtask

    int unsigned r, t_ss, t_sv, t_sv2, p_before;

    initial begin
        clr  = 1'b1;
        leds = 2'b10;
        resp = {8'hA7, 8'h03, 8'h55, 8'h00, 8'h05};
        repeat (3) @(negedge clk);

        check("rst_joy_x", joy_x, 512);
        check("rst_joy_y", joy_y, 512);
        check("rst_btn", btn, 0);
        check("rst_ss", ss, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);

        // First transaction: X=0x3A7, Y=0x055, btn=5
        clr = 1'b0;
        r   = cyc;
        wait_ss_fall(50, t_ss);
        check("first_ss_fall", t_ss - r, 10);
        @(negedge clk);
        check("busy_setup", busy, 1);
        wait_pulse(400, t_sv);
        check("txn_len", t_sv - t_ss, 177);
        check("joy_x_1", joy_x, 935);
        check("joy_y_1", joy_y, 85);
        check("btn_1", btn, 5);
        check("busy_after", busy, 0);
        check("ss_after", ss, 1);
        check("cmd_byte", mosi_cap[39:32], EXP_CMD);
        check("tx_zero_bytes", mosi_cap[31:0], 0);

        // Second poll: garbage in the upper bits of the high bytes
        resp = {8'h12, 8'hFD, 8'h34, 8'hFC, 8'hFA};
        @(negedge clk);
        check("pulse_width", sample_valid, 0);
        check("hold_x", joy_x, 935);
        wait_pulse(400, t_sv2);
        check("poll_period", t_sv2 - t_sv, 187);
        check("joy_x_2", joy_x, 274);
        check("joy_y_2", joy_y, 52);
        check("btn_2", btn, 2);

        // Abort during byte 2
        resp = {8'hEE, 8'h01, 8'hEE, 8'h01, 8'h07};
        @(negedge clk);
        wait_ss_fall(50, t_ss);
        repeat (80) @(negedge clk);
        check("abort_busy_pre", busy, 1);
        p_before = pulses;
        #2 clr = 1'b1;
        #1;
        check("abort_ss", ss, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_joy_x", joy_x, 512);
        check("abort_joy_y", joy_y, 512);
        check("abort_btn", btn, 0);
        repeat (3) @(negedge clk);
        check("abort_no_pulse", pulses, p_before);

        // Recovery transaction: X=0x25A, Y=0x1C3, btn=3
        resp = {8'h5A, 8'h02, 8'hC3, 8'h01, 8'h03};
        clr  = 1'b0;
        r    = cyc;
        wait_ss_fall(50, t_ss);
        check("recover_ss_fall", t_ss - r, 10);
        wait_pulse(400, t_sv);
        check("recover_len", t_sv - t_ss, 177);
        check("joy_x_3", joy_x, 602);
        check("joy_y_3", joy_y, 451);
        check("btn_3", btn, 3);
        @(negedge clk);
        check("pulse_count", pulses, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
